// File: rtl/bitwise_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_logic_pipe
// Description : Registered bitwise logic unit (AND / OR / XOR / NAND) over two
//               WIDTH-bit operands. Results are buffered in a 2-entry output
//               queue. Both sides use a valid/ready handshake.
//               Optional accumulator (macro BITWISE_LOGIC_PIPE_ACC_EN) lets
//               the previous result stand in for operand B.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk      in   1      clock, rising edge
//   resetN   in   1      asynchronous active-low reset
//   inValid  in   1      operand transaction offered
//   inReady  out  1      queue has room (registered state only)
//   inA      in   WIDTH  operand A
//   inB      in   WIDTH  operand B
//   op       in   2      00 AND, 01 OR, 10 XOR, 11 NAND
//   accSel   in   1      operand B = acc (accumulator build only)
//   accClr   in   1      clear acc (accumulator build only)
//   outValid out  1      queue head holds a result
//   outReady in   1      consumer takes the head
//   out      out  WIDTH  queue head result
//   zero     out  1      out == 0
// ============================================================================
module bitwise_logic_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic [1:0]       op,
   input  logic             accSel,
   input  logic             accClr,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] out,
   output logic             zero
);

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   localparam logic [1:0] CNT_EMPTY = 2'd0;
   localparam logic [1:0] CNT_ONE   = 2'd1;
   localparam logic [1:0] CNT_FULL  = 2'd2;

   logic [1:0]       count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [WIDTH-1:0] operand_b;
   logic [WIDTH-1:0] result;
   logic             push;
   logic             pop;

   // Handshake flags depend on the registered count only, so inReady has no
   // combinational path from outReady.
   assign inReady  = (count_q != CNT_FULL);
   assign outValid = (count_q != CNT_EMPTY);
   assign out      = head_q;
   assign zero     = ~|head_q;
   assign push     = inValid && inReady;
   assign pop      = outValid && outReady;

`ifdef BITWISE_LOGIC_PIPE_ACC_EN
   logic [WIDTH-1:0] acc_q, acc_d;

   // Operand B reads the pre-update acc, so a same-cycle clear does not
   // affect the operation being accepted.
   assign operand_b = accSel ? acc_q : inB;

   always_comb begin
      acc_d = acc_q;
      if (push) begin
         acc_d = result;
      end
      // Clear wins over the accept update.
      if (accClr) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   logic unused_acc_ctl;
   assign unused_acc_ctl = accSel ^ accClr;
   assign operand_b      = inB;
`endif

   always_comb begin
      result = '0;
      case (op)
         OP_AND:  result = inA & operand_b;
         OP_OR:   result = inA | operand_b;
         OP_XOR:  result = inA ^ operand_b;
         OP_NAND: result = ~(inA & operand_b);
         default: result = '0;
      endcase
   end

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (count_q)
         CNT_EMPTY: begin
            if (push) begin
               head_d  = result;
               count_d = CNT_ONE;
            end
         end
         CNT_ONE: begin
            if (push && pop) begin
               // Head leaves and the new result takes its place.
               head_d = result;
            end else if (push) begin
               tail_d  = result;
               count_d = CNT_FULL;
            end else if (pop) begin
               // Clear the vacated head so an empty queue presents out = 0.
               head_d  = '0;
               count_d = CNT_EMPTY;
            end
         end
         CNT_FULL: begin
            if (pop) begin
               head_d  = tail_q;
               tail_d  = '0;
               count_d = CNT_ONE;
            end
         end
         default: begin
            count_d = CNT_EMPTY;
            head_d  = '0;
            tail_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count_q <= CNT_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitwise_logic_pipe
// Description : Self-checking bench for bitwise_logic_pipe (WIDTH=8). A
//               reference model pushes expected results into a queue on every
//               accept; the monitor pops and compares on every output pop.
//               A vector table covers the basic operations; hand-written
//               sequences cover back-pressure, streaming, accumulator and
//               mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_logic_pipe;

   localparam int WIDTH = 8;
`ifdef BITWISE_LOGIC_PIPE_ACC_EN
   localparam bit ACC = 1'b1;
`else
   localparam bit ACC = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             resetN = 1'b0;
   logic             inValid = 1'b0;
   logic             inReady;
   logic [WIDTH-1:0] inA = '0;
   logic [WIDTH-1:0] inB = '0;
   logic [1:0]       op = 2'b00;
   logic             accSel = 1'b0;
   logic             accClr = 1'b0;
   logic             outValid;
   logic             outReady = 1'b0;
   logic [WIDTH-1:0] out;
   logic             zero;

   bitwise_logic_pipe #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .resetN   (resetN),
      .inValid  (inValid),
      .inReady  (inReady),
      .inA      (inA),
      .inB      (inB),
      .op       (op),
      .accSel   (accSel),
      .accClr   (accClr),
      .outValid (outValid),
      .outReady (outReady),
      .out      (out),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   logic [WIDTH-1:0] sb[$];
   logic [WIDTH-1:0] m_acc = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] f_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [1:0] o);
      case (o)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   // Monitor: at the negedge the handshake inputs are settled for the next
   // rising edge, so pop/push decided here happen on that edge.
   always @(negedge clk) begin
      logic [WIDTH-1:0] b_eff;
      logic [WIDTH-1:0] r;
      if (resetN) begin
         if (outValid && outReady) begin
            pops++;
            if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
            else check("sb_data", out, sb.pop_front());
         end
         if (inValid && inReady) begin
            b_eff = (ACC && accSel) ? m_acc : inB;
            r = f_op(inA, b_eff, op);
            sb.push_back(r);
            if (ACC) m_acc = r;
         end
         if (ACC && accClr) m_acc = '0;
      end
   end

   // Offers one transaction starting just after a rising edge; returns just
   // after the edge on which it was accepted.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] o,
                       input logic sel, input logic clr);
      int n;
      n = 0;
      inValid = 1'b1; inA = a; inB = b; op = o; accSel = sel; accClr = clr;
      @(negedge clk);
      while (!inReady && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!inReady) check("send_timeout", n, 0);
      @(posedge clk); #1;
      inValid = 1'b0; accSel = 1'b0; accClr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      outReady = 1'b1;
      while ((sb.size() != 0 || outValid) && n < 50) begin
         n++;
         idle(1);
      end
      check(name, sb.size(), 0);
   endtask

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [1:0]       o;
      logic [WIDTH-1:0] exp;
      logic             zexp;
   } vec_t;

   vec_t vecs[5];
   int   p0;
   logic [WIDTH-1:0] exp_v;

   initial begin
      vecs[0] = '{8'hC3, 8'hF0, 2'b00, 8'hC0, 1'b0};
      vecs[1] = '{8'hC3, 8'hF0, 2'b01, 8'hF3, 1'b0};
      vecs[2] = '{8'hC3, 8'hF0, 2'b10, 8'h33, 1'b0};
      vecs[3] = '{8'hC3, 8'hF0, 2'b11, 8'h3F, 1'b0};
      vecs[4] = '{8'hAA, 8'h55, 2'b00, 8'h00, 1'b1};

      // Reset state, then idle after release.
      #12;
      check("rst_outValid", outValid, 0);
      check("rst_out", out, 0);
      check("rst_zero", zero, 1);
      check("rst_inReady", inReady, 1);
      @(posedge clk); #1;
      resetN = 1'b1;
      idle(3);
      check("idle_outValid", outValid, 0);
      check("idle_out", out, 0);
      check("idle_inReady", inReady, 1);

      // Operation table, one cycle latency from an empty queue.
      outReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].o, 1'b0, 1'b0);
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), outValid, 1);
         check($sformatf("vec%0d_out", i), out, vecs[i].exp);
         check($sformatf("vec%0d_zero", i), zero, vecs[i].zexp);
         @(posedge clk); #1;
      end
      drain("vec_drain");

      // Back-pressure: two fill the queue, third is held.
      outReady = 1'b0;
      p0 = pops;
      send(8'h11, 8'hFF, 2'b00, 1'b0, 1'b0);
      send(8'h22, 8'hFF, 2'b00, 1'b0, 1'b0);
      check("bp_full_inReady", inReady, 0);
      inValid = 1'b1; inA = 8'h33; inB = 8'hFF; op = 2'b00;
      idle(3);
      check("bp_held_inReady", inReady, 0);
      check("bp_hold_out", out, 8'h11);
      check("bp_hold_valid", outValid, 1);
      outReady = 1'b1;
      @(negedge clk);
      while (!inReady) @(negedge clk);
      @(posedge clk); #1;
      inValid = 1'b0;
      drain("bp_drain");
      check("bp_pop_count", pops - p0, 3);

      // Streaming at count 1: push and pop every cycle.
      p0 = pops;
      send(8'h5A, 8'h0F, 2'b10, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
         check($sformatf("stream%0d_inReady", i), inReady, 1);
         check($sformatf("stream%0d_valid", i), outValid, 1);
      end
      drain("stream_drain");
      check("stream_pop_count", pops - p0, 9);

      // Accumulator sequence.
      accClr = 1'b1;
      idle(1);
      accClr = 1'b0;
      send(8'hFF, 8'h0F, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      check("acc_load_out", out, 8'hFF);
      @(posedge clk); #1;
      send(8'h3C, 8'h5A, 2'b00, 1'b1, 1'b0);
      @(negedge clk);
      exp_v = ACC ? 8'h3C : 8'h18;
      check("acc_and_out", out, exp_v);
      @(posedge clk); #1;
      send(8'h81, 8'h0F, 2'b01, 1'b1, 1'b1);
      @(negedge clk);
      exp_v = ACC ? 8'hBD : 8'h8F;
      check("acc_preclr_out", out, exp_v);
      @(posedge clk); #1;
      send(8'h12, 8'h0F, 2'b01, 1'b1, 1'b0);
      @(negedge clk);
      exp_v = ACC ? 8'h12 : 8'h1F;
      check("acc_cleared_out", out, exp_v);
      @(posedge clk); #1;
      drain("acc_drain");

      // Reset with a full queue.
      outReady = 1'b0;
      send(8'h77, 8'hF0, 2'b00, 1'b0, 1'b0);
      send(8'h66, 8'h0F, 2'b01, 1'b0, 1'b0);
      check("mid_full_inReady", inReady, 0);
      resetN = 1'b0;
      sb.delete();
      m_acc = '0;
      #2;
      check("mid_rst_valid", outValid, 0);
      check("mid_rst_out", out, 0);
      check("mid_rst_zero", zero, 1);
      check("mid_rst_inReady", inReady, 1);
      @(posedge clk); #1;
      resetN = 1'b1;
      outReady = 1'b1;
      p0 = pops;
      idle(5);
      check("mid_after_valid", outValid, 0);
      check("mid_after_pops", pops - p0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
